// File: rtl/mem_access_controller.sv
// M-stage data-memory sequencer: one access at a time over a req/gnt/rvalid port,
// stalling the pipeline until the access completes, is rejected, or times out.

module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic       i_byte_op,
  input  logic [1:0] i_lane,
  input  logic [7:0] i_store_byte,
  input  logic [7:0] i_word_byte,
  output logic       o_be,
  output logic [7:0] o_wdata
);
  // Byte stores replicate the low byte so the memory can pick any lane via be.
  assign o_be    = i_byte_op ? (i_lane == 2'(LANE)) : 1'b1;
  assign o_wdata = i_byte_op ? i_store_byte : i_word_byte;
endmodule

module mem_access_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    memory_m_i,
  input  logic                    mem_write_m_i,
  input  logic                    byte_op_m_i,
  input  logic [DATA_WIDTH-1:0]   alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]   write_data_m_i,
  output logic                    stall_o,
  output logic [DATA_WIDTH-1:0]   read_data_o,
  output logic                    read_valid_o,
  output logic                    err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic                    we;
    logic                    byte_op;
    logic [DATA_WIDTH-1:2]   addr_hi;
    logic [1:0]              lane;
    logic [NUM_LANES-1:0]    be;
    logic [DATA_WIDTH-1:0]   wdata;
  } req_t;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  req_t                 r_req;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                 r_rvalid;
  logic                 r_err;

  logic [NUM_LANES-1:0]        w_be;
  logic [NUM_LANES-1:0][7:0]   w_wdata;
  req_t                        w_req_next;
  logic                        w_misalign;
  logic                        w_tmo;
  logic [CNT_WIDTH-1:0]        w_cnt_inc;
  logic [7:0]                  w_rbyte;
  logic [DATA_WIDTH-1:0]       w_load_data;
  logic                        w_in_req;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_lane #(.LANE(g)) u_lane (
      .i_byte_op   (byte_op_m_i),
      .i_lane      (alu_result_m_i[1:0]),
      .i_store_byte(write_data_m_i[7:0]),
      .i_word_byte (write_data_m_i[8*g +: 8]),
      .o_be        (w_be[g]),
      .o_wdata     (w_wdata[g])
    );
  end

  always_comb begin
    w_req_next         = '0;
    w_req_next.we      = mem_write_m_i;
    w_req_next.byte_op = byte_op_m_i;
    w_req_next.addr_hi = alu_result_m_i[DATA_WIDTH-1:2];
    w_req_next.lane    = alu_result_m_i[1:0];
    w_req_next.be      = w_be;
    w_req_next.wdata   = w_wdata;
  end

  assign w_misalign = !byte_op_m_i && (alu_result_m_i[1:0] != 2'b00);
  assign w_tmo      = (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  // Saturate so a load granted on the last REQ cycle still times out in WAIT.
  assign w_cnt_inc  = w_tmo ? r_cnt : r_cnt + CNT_WIDTH'(1);

  assign w_rbyte     = mem_rdata_i[{r_req.lane, 3'b000} +: 8];
  assign w_load_data = r_req.byte_op ? {{(DATA_WIDTH-8){1'b0}}, w_rbyte} : mem_rdata_i;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_req    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (memory_m_i) begin
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_req   <= w_req_next;
              r_cnt   <= '0;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_inc;
          if (mem_gnt_i) begin
            r_state <= r_req.we ? S_DONE : S_WAIT;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (mem_rvalid_i) begin
            r_rdata  <= w_load_data;
            r_rvalid <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_req = (r_state == S_REQ);

  // DONE releases the stall so the finished instruction leaves M exactly once.
  assign stall_o      = rst_ni && ((r_state == S_IDLE) ? memory_m_i : (r_state != S_DONE));
  assign read_data_o  = r_rdata;
  assign read_valid_o = r_rvalid;
  assign err_o        = r_err;
  assign mem_req_o    = w_in_req;
  assign mem_we_o     = w_in_req && r_req.we;
  assign mem_addr_o   = w_in_req ? {r_req.addr_hi, 2'b00} : '0;
  assign mem_be_o     = w_in_req ? r_req.be : '0;
  assign mem_wdata_o  = w_in_req ? r_req.wdata : '0;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench: a timeline model predicts every cycle of each access from its
// grant/response delays; a negedge process compares the DUT against it.

module tb_mem_access_controller;
  localparam int T = 16;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        memory_m_i = 1'b0, mem_write_m_i = 1'b0, byte_op_m_i = 1'b0;
  logic [31:0] alu_result_m_i = '0, write_data_m_i = '0;
  logic        stall_o, read_valid_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] read_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_access_controller #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .memory_m_i(memory_m_i), .mem_write_m_i(mem_write_m_i), .byte_op_m_i(byte_op_m_i),
    .alu_result_m_i(alu_result_m_i), .write_data_m_i(write_data_m_i),
    .stall_o(stall_o), .read_data_o(read_data_o), .read_valid_o(read_valid_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        all;
    logic        chk_rd;
    logic        done;
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t expq[$];
  exp_t ce;
  int n_cmp = 0, n_err = 0;
  int n_stall = 0, n_req = 0;
  logic [31:0] l_rd, l_addr, l_wdata;
  logic [3:0]  l_be;
  logic        l_rv, l_err, l_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] f_be(input logic bop, input logic [31:0] a);
    logic [1:0] l;
    l = a[1:0];
    return bop ? (4'b0001 << l) : 4'hF;
  endfunction

  function automatic logic [31:0] f_wd(input logic bop, input logic [31:0] d);
    logic [7:0] b;
    b = d[7:0];
    return bop ? {4{b}} : d;
  endfunction

  function automatic logic [31:0] f_rd(input logic bop, input logic [31:0] a, input logic [31:0] d);
    logic [1:0] l;
    l = a[1:0];
    return bop ? ((d >> (8 * l)) & 32'h0000_00FF) : d;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.all = 0; e.chk_rd = 0; e.done = 0; e.stall = 0; e.req = 0; e.we = 0;
    e.addr = '0; e.be = '0; e.wdata = '0; e.rv = 0; e.rd = '0; e.err = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      ce = expq.pop_front();
      chk("stall_o", 32'(stall_o), 32'(ce.stall));
      chk("mem_req_o", 32'(mem_req_o), 32'(ce.req));
      chk("read_valid_o", 32'(read_valid_o), 32'(ce.rv));
      chk("err_o", 32'(err_o), 32'(ce.err));
      if (ce.req || ce.all) begin
        chk("mem_we_o", 32'(mem_we_o), 32'(ce.we));
        chk("mem_addr_o", mem_addr_o, ce.addr);
        chk("mem_be_o", 32'(mem_be_o), 32'(ce.be));
        chk("mem_wdata_o", mem_wdata_o, ce.wdata);
      end
      if (ce.chk_rd || ce.all) chk("read_data_o", read_data_o, ce.rd);
      if (stall_o) n_stall++;
      if (mem_req_o) begin
        n_req++;
        l_be = mem_be_o; l_addr = mem_addr_o; l_wdata = mem_wdata_o; l_we = mem_we_o;
      end
      if (ce.done) begin
        l_rd = read_data_o; l_rv = read_valid_o; l_err = err_o;
      end
    end
  end

  task automatic drive(input logic m, input logic we, input logic bop, input logic [31:0] a,
                       input logic [31:0] wd, input logic g, input logic rv,
                       input logic [31:0] rd, input exp_t e);
    @(posedge clk); #1;
    memory_m_i = m; mem_write_m_i = we; byte_op_m_i = bop;
    alu_result_m_i = a; write_data_m_i = wd;
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    expq.push_back(e);
  endtask

  // Pipeline has moved on; stray gnt/rvalid must have no effect.
  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, zero_exp());
  endtask

  // g: REQ cycles before gnt; w: WAIT cycles before rvalid (NEVER = no response).
  task automatic run_access(input logic we, input logic bop, input logic [31:0] a,
                            input logic [31:0] wd, input int g, input int w,
                            input logic [31:0] rdata);
    logic mis, to;
    int done, req_end;
    exp_t e;
    mis = !bop && (a[1:0] != 2'b00);
    to = 0;
    if (mis) begin
      done = 1; req_end = 0;
    end else if (g >= T) begin
      to = 1; done = T + 1; req_end = T;
    end else begin
      req_end = 1 + g;
      if (we) done = 2 + g;
      else if (g + 1 + w <= T - 1) done = 3 + g + w;
      else begin to = 1; done = T + 1; end
    end
    n_stall = 0; n_req = 0;
    for (int c = 0; c <= done; c++) begin
      e = zero_exp();
      e.stall = (c < done);
      e.req   = !mis && (c >= 1) && (c <= req_end);
      e.we    = we;
      e.addr  = {a[31:2], 2'b00};
      e.be    = f_be(bop, a);
      e.wdata = f_wd(bop, wd);
      e.done  = (c == done);
      e.rv    = (c == done) && !we && !mis && !to;
      e.err   = (c == done) && (mis || to);
      e.chk_rd = e.rv || e.err;
      e.rd    = e.rv ? f_rd(bop, a, rdata) : 32'h0;
      drive(1'b1, we, bop, a, wd,
            (!mis && g < T && c == 1 + g) || (c == done),
            (!mis && !we && !to && c == 2 + g + w) || (c == done),
            rdata, e);
    end
    idle_cycle();
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    e = zero_exp();
    e.all = 1;
    // Reset held with an access pending: everything must stay at zero.
    memory_m_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1; memory_m_i = 1'b0;
    expq.push_back(e);
    idle_cycle();

    // 1: word load
    run_access(1'b0, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("t1_stall_cycles", n_stall, 3);
    chk("t1_rdata", l_rd, 32'hDEAD_BEEF);
    chk("t1_rvalid", 32'(l_rv), 1);
    // 2: byte store lane 3
    run_access(1'b1, 1'b1, 32'h203, 32'h0000_00A5, 0, 0, 32'h0);
    chk("t2_be", 32'(l_be), 32'h8);
    chk("t2_wdata", l_wdata, 32'hA5A5_A5A5);
    chk("t2_addr", l_addr, 32'h200);
    chk("t2_we", 32'(l_we), 1);
    chk("t2_stall_cycles", n_stall, 2);
    // 3: byte load lane 1
    run_access(1'b0, 1'b1, 32'h001, 32'h0, 0, 0, 32'h1122_3344);
    chk("t3_rdata", l_rd, 32'h0000_0033);
    // 4: misaligned word load
    run_access(1'b0, 1'b0, 32'h102, 32'h0, 0, 0, 32'h0);
    chk("t4_req_cycles", n_req, 0);
    chk("t4_err", 32'(l_err), 1);
    chk("t4_stall_cycles", n_stall, 1);
    // 5: slow grant, then lost response
    run_access(1'b0, 1'b0, 32'h300, 32'h0, 3, 0, 32'hCAFE_F00D);
    chk("t5a_req_cycles", n_req, 4);
    chk("t5a_rdata", l_rd, 32'hCAFE_F00D);
    run_access(1'b0, 1'b0, 32'h304, 32'h0, 0, NEVER, 32'h5555_5555);
    chk("t5b_err", 32'(l_err), 1);
    chk("t5b_rdata", l_rd, 32'h0);
    chk("t5b_stall_cycles", n_stall, 17);

    // extra lanes, waits and timeout boundaries
    run_access(1'b1, 1'b0, 32'h010, 32'h1234_5678, 1, 0, 32'h0);
    run_access(1'b1, 1'b1, 32'h020, 32'h0000_BE7C, 2, 0, 32'h0);
    run_access(1'b0, 1'b1, 32'h043, 32'h0, 0, 2, 32'hAB00_0000);
    run_access(1'b0, 1'b1, 32'h062, 32'h0, 1, 1, 32'h0077_8899);
    run_access(1'b1, 1'b0, 32'h0FE, 32'h0, 0, 0, 32'h0);
    run_access(1'b1, 1'b0, 32'h400, 32'h0F0F_0F0F, NEVER, 0, 32'h0);
    run_access(1'b1, 1'b0, 32'h404, 32'h0A0A_0A0A, T - 1, 0, 32'h0);
    chk("gnt_last_cycle_err", 32'(l_err), 0);
    run_access(1'b0, 1'b0, 32'h500, 32'h0, 0, T - 2, 32'h600D_D00D);
    chk("rvalid_last_cycle", l_rd, 32'h600D_D00D);
    run_access(1'b0, 1'b0, 32'h504, 32'h0, 0, T - 1, 32'h0BAD_0BAD);

    // 6: reset during WAIT, late rvalid ignored
    e = zero_exp(); e.stall = 1;
    drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, e);
    e = zero_exp(); e.stall = 1; e.req = 1; e.addr = 32'h40; e.be = 4'hF;
    drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0, e);
    e = zero_exp(); e.stall = 1;
    drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, e);
    e = zero_exp(); e.all = 1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    expq.push_back(e);
    @(posedge clk); #1;
    rst_ni = 1'b1; memory_m_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    expq.push_back(e);
    idle_cycle();
    @(negedge clk); #1;
    run_access(1'b0, 1'b0, 32'h80, 32'h0, 0, 0, 32'h1357_9BDF);
    chk("t6_after_reset_rdata", l_rd, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
